// File: rtl/fp16_sum_res_pipe.sv
// bfloat16 add/sub pipeline: input capture, unpack, align, add, normalize/round; one op per clock.
// Latency: operands captured on edge N give y/ready after edge N+4. No backpressure; the pipeline always advances.
// Rounding: FP16SUM_RNE_EN selects round-to-nearest-even; when it is undefined the result is truncated.
module fp16_sum_res_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] x1,
    input  logic [15:0] x2,
    input  logic        add_sub,
    input  logic        en,
    output logic [15:0] y,
    output logic        ready
);

    localparam logic [15:0] QNAN    = 16'h7FC0;
    localparam logic [14:0] INF_MAG = 15'h7F80;

    // ---------------- stage 0: operand capture ----------------
    logic [15:0] in_a, in_b;
    logic        in_sub, v0;

    always_ff @(posedge clk) begin
        if (rst) v0 <= 1'b0;
        else     v0 <= en;
        if (en) begin
            in_a   <= x1;
            in_b   <= x2;
            in_sub <= add_sub;
        end
    end

    // ---------------- stage 1: unpack, classify, swap ----------------
    logic       sb_eff, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, swap;
    logic       spec_c;
    logic [15:0] spec_val_c;

    assign sb_eff = in_b[15] ^ in_sub;
    assign a_zero = (in_a[14:7] == 8'h00);
    assign b_zero = (in_b[14:7] == 8'h00);
    assign a_nan  = (in_a[14:7] == 8'hFF) &&  (|in_a[6:0]);
    assign b_nan  = (in_b[14:7] == 8'hFF) &&  (|in_b[6:0]);
    assign a_inf  = (in_a[14:7] == 8'hFF) && !(|in_a[6:0]);
    assign b_inf  = (in_b[14:7] == 8'hFF) && !(|in_b[6:0]);
    assign swap   = (in_b[14:0] > in_a[14:0]);

    always_comb begin
        spec_c     = 1'b1;
        spec_val_c = 16'h0000;
        if (a_nan || b_nan)      spec_val_c = QNAN;
        else if (a_inf && b_inf) spec_val_c = (in_a[15] == sb_eff) ? {in_a[15], INF_MAG} : QNAN;
        else if (a_inf)          spec_val_c = {in_a[15], INF_MAG};
        else if (b_inf)          spec_val_c = {sb_eff, INF_MAG};
        else if (a_zero && b_zero) spec_val_c = {in_a[15] & sb_eff, 15'h0000};
        else if (a_zero)         spec_val_c = {sb_eff, in_b[14:0]};
        else if (b_zero)         spec_val_c = in_a;
        else                     spec_c = 1'b0;
    end

    logic        v1, s1_sign, s1_sub, s1_spec;
    logic [7:0]  s1_exp, s1_diff, s1_ma, s1_mb;
    logic [15:0] s1_spec_val;

    always_ff @(posedge clk) begin
        if (rst) v1 <= 1'b0;
        else     v1 <= v0;
        s1_sign     <= swap ? sb_eff : in_a[15];
        s1_exp      <= swap ? in_b[14:7] : in_a[14:7];
        s1_diff     <= swap ? (in_b[14:7] - in_a[14:7]) : (in_a[14:7] - in_b[14:7]);
        s1_ma       <= {1'b1, swap ? in_b[6:0] : in_a[6:0]};
        s1_mb       <= {1'b1, swap ? in_a[6:0] : in_b[6:0]};
        s1_sub      <= in_a[15] ^ sb_eff;
        s1_spec     <= spec_c;
        s1_spec_val <= spec_val_c;
    end

    // ---------------- stage 2: align smaller significand ----------------
    logic [19:0] shifted;
    logic [9:0]  mb_al_c;
    logic        st_c;

    assign shifted = {s1_mb, 12'h000} >> s1_diff;

    // Beyond a 9-bit shift the whole significand has left the G/R window.
    always_comb begin
        if (s1_diff >= 8'd10) begin
            mb_al_c = 10'h000;
            st_c    = 1'b1;
        end else begin
            mb_al_c = shifted[19:10];
            st_c    = |shifted[9:0];
        end
    end

    logic        v2, s2_sign, s2_sub, s2_spec, s2_st;
    logic [7:0]  s2_exp, s2_ma;
    logic [9:0]  s2_mb;
    logic [15:0] s2_spec_val;

    always_ff @(posedge clk) begin
        if (rst) v2 <= 1'b0;
        else     v2 <= v1;
        s2_sign     <= s1_sign;
        s2_sub      <= s1_sub;
        s2_exp      <= s1_exp;
        s2_ma       <= s1_ma;
        s2_mb       <= mb_al_c;
        s2_st       <= st_c;
        s2_spec     <= s1_spec;
        s2_spec_val <= s1_spec_val;
    end

    // ---------------- stage 3: add / subtract ----------------
    logic [11:0] op_a, op_b;

    assign op_a = {1'b0, s2_ma, 3'b000};
    assign op_b = {1'b0, s2_mb, s2_st};

    logic        v3, s3_sign, s3_spec;
    logic [7:0]  s3_exp;
    logic [11:0] s3_sum;
    logic [15:0] s3_spec_val;

    always_ff @(posedge clk) begin
        if (rst) v3 <= 1'b0;
        else     v3 <= v2;
        s3_sum      <= s2_sub ? (op_a - op_b) : (op_a + op_b);
        s3_sign     <= s2_sign;
        s3_exp      <= s2_exp;
        s3_spec     <= s2_spec;
        s3_spec_val <= s2_spec_val;
    end

    // ---------------- stage 4: normalize, round, pack ----------------
    function automatic logic [3:0] lzc11(input logic [10:0] v);
        lzc11 = 4'd11;
        for (int i = 0; i <= 10; i++) begin
            if (v[i]) lzc11 = 4'(10 - i);
        end
    endfunction

    logic [3:0]  lz;
    logic [10:0] sh;
    logic [7:0]  sig;
    logic        g, r, s;
    logic [9:0]  e_norm, e_fin;
    logic [6:0]  frac;
    logic [15:0] res;

`ifdef FP16SUM_RNE_EN
    logic        rnd;
    logic [8:0]  sig9;
`else
    logic        grs_unused;
    assign grs_unused = ^{g, r, s, sig[7]};
`endif

    always_comb begin
        lz = lzc11(s3_sum[10:0]);
        sh = s3_sum[10:0] << lz;
        if (s3_sum[11]) begin
            sig    = s3_sum[11:4];
            g      = s3_sum[3];
            r      = s3_sum[2];
            s      = |s3_sum[1:0];
            e_norm = {2'b00, s3_exp} + 10'd1;
        end else begin
            sig    = sh[10:3];
            g      = sh[2];
            r      = sh[1];
            s      = sh[0];
            e_norm = {2'b00, s3_exp} - {6'b000000, lz};
        end
        e_fin = e_norm;
`ifdef FP16SUM_RNE_EN
        rnd  = g & (r | s | sig[0]);
        sig9 = {1'b0, sig} + {8'h00, rnd};
        if (sig9[8]) begin
            frac  = 7'h00;
            e_fin = e_norm + 10'd1;
        end else begin
            frac  = sig9[6:0];
        end
`else
        frac = sig[6:0];
`endif
        if (s3_spec)                           res = s3_spec_val;
        else if (s3_sum == 12'h000)            res = 16'h0000;
        else if (e_fin[9] || e_fin == 10'd0)   res = {s3_sign, 15'h0000};
        else if (e_fin >= 10'd255)             res = {s3_sign, INF_MAG};
        else                                   res = {s3_sign, e_fin[7:0], frac};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready <= 1'b0;
            y     <= 16'h0000;
        end else begin
            ready <= v3;
            if (v3) y <= res;
        end
    end

endmodule

// File: tb/tb_fp16_sum_res_pipe.sv
// Directed-vector bench for fp16_sum_res_pipe: scoreboard checks every result value and its 4-cycle latency.
module tb_fp16_sum_res_pipe;

    logic        clk = 1'b0;
    logic        rst, en, add_sub;
    logic [15:0] x1, x2;
    logic [15:0] y;
    logic        ready;

    fp16_sum_res_pipe dut (
        .clk     (clk),
        .rst     (rst),
        .x1      (x1),
        .x2      (x2),
        .add_sub (add_sub),
        .en      (en),
        .y       (y),
        .ready   (ready)
    );

    always #5 clk = ~clk;

`ifdef FP16SUM_RNE_EN
    localparam logic [15:0] P411 = 16'h4411;
    localparam logic [15:0] N411 = 16'hC411;
    localparam logic [15:0] TIE  = 16'h4000;
`else
    localparam logic [15:0] P411 = 16'h4410;
    localparam logic [15:0] N411 = 16'hC410;
    localparam logic [15:0] TIE  = 16'h3FFF;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_ready  = 0;
    int n_pushed = 0;
    int base_ready;

    logic [15:0] exp_q[$];
    int          cap_q[$];
    string       tag_q[$];

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, expv);
        end
    endtask

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (ready === 1'b1) begin
            n_ready++;
            if (exp_q.size() == 0) begin
                chk_eq("unexpected_ready", 32'(n_ready), 32'(n_pushed));
            end else begin
                logic [15:0] e;
                int          c;
                string       t;
                e = exp_q.pop_front();
                c = cap_q.pop_front();
                t = tag_q.pop_front();
                chk_eq(t, 32'(y), 32'(e));
                chk_eq({t, "_lat"}, 32'(cyc - c), 32'd4);
            end
        end
    end

    task automatic issue(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic op, input logic [15:0] e);
        @(negedge clk);
        x1 = a; x2 = b; add_sub = op; en = 1'b1;
        exp_q.push_back(e);
        cap_q.push_back(cyc + 1);
        tag_q.push_back(tag);
        n_pushed++;
    endtask

    task automatic idle();
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        chk_eq("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; add_sub = 1'b0; x1 = 16'h0000; x2 = 16'h0000;
        repeat (2) @(negedge clk);
        chk_eq("reset_y", 32'(y), 32'h0000);
        chk_eq("reset_ready", 32'(ready), 32'd0);
        rst = 1'b0;

        // Adds, all sign combinations, back to back
        issue("add_pp", 16'h4237, 16'h441C, 1'b0, 16'h4427);
        issue("add_np", 16'hC237, 16'h441C, 1'b0, P411);
        issue("add_pn", 16'h4237, 16'hC41C, 1'b0, N411);
        issue("add_nn", 16'hC237, 16'hC41C, 1'b0, 16'hC427);
        idle();
        drain();

        // Subtracts, same pairs
        issue("sub_pp", 16'h4237, 16'h441C, 1'b1, N411);
        issue("sub_np", 16'hC237, 16'h441C, 1'b1, 16'hC427);
        issue("sub_pn", 16'h4237, 16'hC41C, 1'b1, 16'h4427);
        issue("sub_nn", 16'hC237, 16'hC41C, 1'b1, P411);
        idle();
        drain();

        // Rounding, cancellation, overflow, specials: nine consecutive ops
        issue("round_sticky", 16'h441C, 16'h4237, 1'b1, P411);
        issue("round_tie",    16'h3FFF, 16'h3B80, 1'b0, TIE);
        issue("cancel",       16'h4237, 16'h4237, 1'b1, 16'h0000);
        issue("overflow",     16'h7F7F, 16'h7F7F, 1'b0, 16'h7F80);
        issue("inf_m_inf",    16'h7F80, 16'h7F80, 1'b1, 16'h7FC0);
        issue("nan_in",       16'h7FC1, 16'h3F80, 1'b0, 16'h7FC0);
        issue("zero_m_one",   16'h0000, 16'h3F80, 1'b1, 16'hBF80);
        issue("inf_p_fin",    16'hFF80, 16'h3F80, 1'b0, 16'hFF80);
        issue("one_p_one",    16'h3F80, 16'h3F80, 1'b0, 16'h4000);
        idle();
        drain();

        repeat (3) @(negedge clk);
        chk_eq("hold_y", 32'(y), 32'h4000);

        // Reset with two ops in flight, and en asserted alongside rst
        @(negedge clk); x1 = 16'h3F80; x2 = 16'h3F80; add_sub = 1'b0; en = 1'b1;
        @(negedge clk); x1 = 16'h4237; x2 = 16'h441C;
        @(negedge clk); rst = 1'b1; x1 = 16'h441C; x2 = 16'h4237;
        @(negedge clk); rst = 1'b0; en = 1'b0;
        base_ready = n_ready;
        chk_eq("rst_ready", 32'(ready), 32'd0);
        chk_eq("rst_y", 32'(y), 32'h0000);
        repeat (6) @(negedge clk);
        chk_eq("rst_no_ready", 32'(n_ready), 32'(base_ready));
        chk_eq("rst_y_hold", 32'(y), 32'h0000);

        issue("post_rst", 16'h4237, 16'h441C, 1'b0, 16'h4427);
        idle();
        drain();

        chk_eq("ready_count", 32'(n_ready), 32'(n_pushed));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
